conv_nm_pipe: RTL

CONV_NM_PIPE -- requirements
Module: conv_nm_pipe

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_mem.sv | 27 ++
 rtl/conv_nm_pipe.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the N-by-M streaming convolution pipeline.
//   state_t   : controller states (LOAD, MAC, OUT)
//   out_width : result width 2*T + clog2(M), wide enough for an M-tap
//               full-precision signed sum of T x T products.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int unsigned out_width(input int unsigned t, input int unsigned m);
    return 2 * t + $clog2(m);
  endfunction

endpackage

// File: rtl/conv_mem.sv
// Single-port memory, synchronous write-enable and synchronous read.
// Ports:
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
// Contents are not reset.
module conv_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_nm_pipe.sv
// Streaming 1-D valid convolution: loads x[0..N-1] and f[0..M-1] over two
// independent valid/ready streams, then emits y[i] = sum_j x[i+j]*f[j] for
// i = 0..N-M on a valid/ready output stream.
// Datapath: memory read -> registered signed multiply -> W-bit accumulate.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   s_data_x/s_valid_x/s_ready_x: x sample stream
//   s_data_f/s_valid_f/s_ready_f: f tap stream
//   m_data_y/m_valid_y/m_ready_y: result stream (registered data/valid)
// Build option: CONV_RELU_EN clamps negative results to zero.
module conv_nm_pipe
  import conv_pkg::*;
#(
  parameter  int unsigned N = 8,
  parameter  int unsigned M = 4,
  parameter  int unsigned T = 8,
  localparam int unsigned W = out_width(T, M)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] s_data_x,
  input  logic                s_valid_x,
  output logic                s_ready_x,
  input  logic signed [T-1:0] s_data_f,
  input  logic                s_valid_f,
  output logic                s_ready_f,
  output logic signed [W-1:0] m_data_y,
  output logic                m_valid_y,
  input  logic                m_ready_y
);

  localparam int unsigned AXW = $clog2(N);
  localparam int unsigned AFW = $clog2(M);
  localparam int unsigned CXW = $clog2(N + 1);
  localparam int unsigned CFW = $clog2(M + 1);

  state_t               state;
  logic [CXW-1:0]       cnt_x, cnt_x_nxt;
  logic [CFW-1:0]       cnt_f, cnt_f_nxt;
  logic [AXW-1:0]       idx_i;
  logic [CFW-1:0]       k;
  logic                 rd_v, rd_last, p_v, p_last;
  logic signed [2*T-1:0] prod;
  logic signed [W-1:0]  acc, acc_sum, y_res;
  logic                 fire_x, fire_f, fire_y, issue;
  logic [AXW-1:0]       addr_x;
  logic [AFW-1:0]       addr_f;
  logic signed [T-1:0]  rdata_x, rdata_f;

  conv_mem #(.WIDTH(T), .DEPTH(N)) u_mem_x (
    .clk   (clk),
    .we    (fire_x),
    .addr  (addr_x),
    .wdata (s_data_x),
    .rdata (rdata_x)
  );

  conv_mem #(.WIDTH(T), .DEPTH(M)) u_mem_f (
    .clk   (clk),
    .we    (fire_f),
    .addr  (addr_f),
    .wdata (s_data_f),
    .rdata (rdata_f)
  );

  // Handshakes, next counts, memory addressing and the result value.
  always_comb begin
    fire_x    = s_valid_x & s_ready_x;
    fire_f    = s_valid_f & s_ready_f;
    fire_y    = m_valid_y & m_ready_y;
    cnt_x_nxt = cnt_x + CXW'(fire_x);
    cnt_f_nxt = cnt_f + CFW'(fire_f);
    issue     = (state == MAC) && (k < CFW'(M));
    // Memories are written by arrival count in LOAD and read at x[i+k], f[k] otherwise.
    addr_x    = (state == LOAD) ? AXW'(cnt_x) : AXW'(32'(idx_i) + 32'(k));
    addr_f    = (state == LOAD) ? AFW'(cnt_f) : AFW'(k);
    acc_sum   = acc + W'(prod);
`ifdef CONV_RELU_EN
    y_res     = acc_sum[W-1] ? '0 : acc_sum;
`else
    y_res     = acc_sum;
`endif
  end

  // Controller and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      cnt_x     <= '0;
      cnt_f     <= '0;
      idx_i     <= '0;
      k         <= '0;
      rd_v      <= 1'b0;
      rd_last   <= 1'b0;
      p_v       <= 1'b0;
      p_last    <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      m_valid_y <= 1'b0;
      m_data_y  <= '0;
      s_ready_x <= 1'b0;
      s_ready_f <= 1'b0;
    end else begin
      // Read -> multiply -> accumulate; a tap is in flight while its flag is set.
      rd_v    <= issue;
      rd_last <= issue && (k == CFW'(M - 1));
      p_v     <= rd_v;
      p_last  <= rd_last;
      if (rd_v) prod <= rdata_x * rdata_f;
      // Clearing on the last tap leaves acc at zero when the next y[i] starts.
      if (p_v) acc <= p_last ? '0 : acc_sum;

      case (state)
        LOAD: begin
          cnt_x <= cnt_x_nxt;
          cnt_f <= cnt_f_nxt;
          if (cnt_x_nxt == CXW'(N) && cnt_f_nxt == CFW'(M)) begin
            state     <= MAC;
            idx_i     <= '0;
            k         <= '0;
            s_ready_x <= 1'b0;
            s_ready_f <= 1'b0;
          end else begin
            s_ready_x <= cnt_x_nxt < CXW'(N);
            s_ready_f <= cnt_f_nxt < CFW'(M);
          end
        end
        MAC: begin
          if (issue) k <= k + CFW'(1);
          if (p_v && p_last) begin
            state     <= OUT;
            m_valid_y <= 1'b1;
            m_data_y  <= y_res;
          end
        end
        OUT: begin
          // Hold data and issue nothing until the result is taken.
          if (fire_y) begin
            m_valid_y <= 1'b0;
            if (idx_i == AXW'(N - M)) begin
              state     <= LOAD;
              cnt_x     <= '0;
              cnt_f     <= '0;
              s_ready_x <= 1'b1;
              s_ready_f <= 1'b1;
            end else begin
              state <= MAC;
              idx_i <= idx_i + AXW'(1);
              k     <= '0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
